// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare: gshare direction predictor with a direct-mapped BTB and a checkpointed speculative GHR.
// Define BP_STATS_EN to build the resolved-branch and mispredict counters.
module branch_predictor_gshare #(
  parameter int PC_WIDTH = 32,
  parameter int GHR_BITS = 8,
  parameter int BTB_BITS = 6,
  parameter logic [1:0] PHT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_f,
  input  logic [PC_WIDTH-1:0] pc_f,
  output logic                branchfound_f,
  output logic [PC_WIDTH-1:0] predict_pc_f,
  output logic [GHR_BITS-1:0] ghr_f,
  input  logic                update_e,
  input  logic                branchfound_e,
  input  logic                branchtaken_e,
  input  logic [PC_WIDTH-1:0] pc_e,
  input  logic [PC_WIDTH-1:0] pcbranch_e,
  input  logic [GHR_BITS-1:0] ghr_e,
  output logic                mispredict_e,
  output logic [PC_WIDTH-1:0] mispredict_pc_e,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);
  localparam int TAG_W = PC_WIDTH - 2 - BTB_BITS;
  logic [GHR_BITS-1:0] ghr;
  logic [1:0] pht [2**GHR_BITS];
  logic [2**BTB_BITS-1:0] btb_valid;
  logic [TAG_W-1:0] btb_tag [2**BTB_BITS];
  logic [PC_WIDTH-1:0] btb_target [2**BTB_BITS];
  logic [BTB_BITS-1:0] idx_f, idx_e;
  logic [GHR_BITS-1:0] pht_f, pht_e;
  logic [1:0] cnt_e;
  logic hit;
  assign idx_f = pc_f[BTB_BITS+1:2];
  assign idx_e = pc_e[BTB_BITS+1:2];
  assign pht_f = pc_f[GHR_BITS+1:2] ^ ghr;
  assign pht_e = pc_e[GHR_BITS+1:2] ^ ghr_e;
  assign cnt_e = pht[pht_e];
  assign hit = btb_valid[idx_f] && (btb_tag[idx_f] == pc_f[PC_WIDTH-1:BTB_BITS+2]);
  assign branchfound_f = hit & pht[pht_f][1];
  assign predict_pc_f = branchfound_f ? btb_target[idx_f] : pc_f + PC_WIDTH'(4);
  assign ghr_f = ghr;
  assign mispredict_e = update_e & (branchfound_e ^ branchtaken_e);
  assign mispredict_pc_e = branchtaken_e ? pcbranch_e : pc_e + PC_WIDTH'(4);
  // restore from the EXE checkpoint takes priority over fetch speculation
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ghr <= '0;
      btb_valid <= '0;
      for (int i = 0; i < 2**GHR_BITS; i++) pht[i] <= PHT_INIT;
    end else begin
      ghr <= mispredict_e ? {ghr_e[GHR_BITS-2:0], branchtaken_e} :
             (!stall_f && hit) ? {ghr[GHR_BITS-2:0], branchfound_f} : ghr;
      if (update_e) begin
        pht[pht_e] <= branchtaken_e ? ((cnt_e == 2'b11) ? cnt_e : cnt_e + 2'd1)
                                    : ((cnt_e == 2'b00) ? cnt_e : cnt_e - 2'd1);
        if (branchtaken_e) btb_valid[idx_e] <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (update_e && branchtaken_e) begin
      btb_tag[idx_e] <= pc_e[PC_WIDTH-1:BTB_BITS+2];
      btb_target[idx_e] <= pcbranch_e;
    end
`ifdef BP_STATS_EN
  logic [31:0] n_br, n_mis;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      n_br <= '0;
      n_mis <= '0;
    end else begin
      if (update_e) n_br <= n_br + 32'd1;
      if (mispredict_e) n_mis <= n_mis + 32'd1;
    end
  assign stat_branches = n_br;
  assign stat_mispredicts = n_mis;
`else
  assign stat_branches = '0;
  assign stat_mispredicts = '0;
`endif
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb_branch_predictor_gshare: directed stimulus feeding an expectation queue drained by a negedge monitor.
module tb_branch_predictor_gshare;
  logic clk = 0, reset = 1, stall_f = 1, update_e = 0, branchfound_e = 0, branchtaken_e = 0;
  logic [31:0] pc_f = 0, pc_e = 0, pcbranch_e = 0;
  logic [7:0] ghr_e = 0;
  logic branchfound_f, mispredict_e;
  logic [31:0] predict_pc_f, mispredict_pc_e, stat_branches, stat_mispredicts;
  logic [7:0] ghr_f;
  int checks = 0, failures = 0;
  typedef struct { string name; int sel; logic [31:0] val; } exp_t;
  exp_t q[$];
  localparam int BF = 0, PPC = 1, GHR = 2, MIS = 3, MPC = 4, SB = 5, SM = 6;

  branch_predictor_gshare dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .pc_f(pc_f),
    .branchfound_f(branchfound_f), .predict_pc_f(predict_pc_f), .ghr_f(ghr_f),
    .update_e(update_e), .branchfound_e(branchfound_e), .branchtaken_e(branchtaken_e),
    .pc_e(pc_e), .pcbranch_e(pcbranch_e), .ghr_e(ghr_e),
    .mispredict_e(mispredict_e), .mispredict_pc_e(mispredict_pc_e),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      BF:  return {31'd0, branchfound_f};
      PPC: return predict_pc_f;
      GHR: return {24'd0, ghr_f};
      MIS: return {31'd0, mispredict_e};
      MPC: return mispredict_pc_e;
      SB:  return stat_branches;
      default: return stat_mispredicts;
    endcase
  endfunction

  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.val);
      end
    end

  task automatic expect_val(string n, int s, logic [31:0] v);
    q.push_back('{n, s, v});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic train(logic [31:0] pc, logic [31:0] tgt, logic [7:0] g, logic found, logic taken);
    update_e = 1; pc_e = pc; pcbranch_e = tgt; ghr_e = g; branchfound_e = found; branchtaken_e = taken;
  endtask

  initial begin
    cyc();
    pc_f = 32'h40;
    expect_val("rst_bf", BF, 0); expect_val("rst_ppc", PPC, 32'h44);
    expect_val("rst_ghr", GHR, 0); expect_val("rst_mis", MIS, 0);
    cyc();
    reset = 0;
    // two taken updates at 0x100 with correct prediction so GHR stays 0
    train(32'h100, 32'h200, 8'h00, 1, 1);
    expect_val("train_nomis", MIS, 0);
    cyc();
    cyc();
    update_e = 0; pc_f = 32'h100;
    expect_val("t2_bf", BF, 1); expect_val("t2_ppc", PPC, 32'h200); expect_val("t2_ghr", GHR, 0);
    // update_e low masks a found/taken disagreement
    branchfound_e = 1; branchtaken_e = 0;
    expect_val("noupd_mis", MIS, 0);
    cyc();
    train(32'h100, 32'h200, 8'h00, 1, 1);
    repeat (5) cyc();
    train(32'h100, 32'h200, 8'h00, 1, 0);
    expect_val("nt1_mis", MIS, 1); expect_val("nt1_mpc", MPC, 32'h104);
    cyc();
    update_e = 0;
    expect_val("sat_bf", BF, 1); expect_val("sat_ppc", PPC, 32'h200);
    cyc();
    train(32'h100, 32'h200, 8'h00, 1, 0);
    expect_val("readold_bf", BF, 1);
    cyc();
    update_e = 0;
    expect_val("nt2_bf", BF, 0); expect_val("nt2_ppc", PPC, 32'h104); expect_val("nt2_ghr", GHR, 0);
    cyc();
    // mispredict restore in the same cycle as an unstalled fetch hit
    stall_f = 0;
    train(32'h304, 32'h480, 8'hA5, 0, 1);
    expect_val("t4_mis", MIS, 1); expect_val("t4_mpc", MPC, 32'h480);
    cyc();
    update_e = 0; stall_f = 1;
    expect_val("t4_ghr", GHR, 32'h4B);
    expect_val("t4_bf", BF, 0);
`ifdef BP_STATS_EN
    expect_val("stat_br", SB, 10); expect_val("stat_mis", SM, 3);
`else
    expect_val("stat_br", SB, 0); expect_val("stat_mis", SM, 0);
`endif
    cyc();
    expect_val("stall2_ghr", GHR, 32'h4B);
    cyc();
    expect_val("stall3_ghr", GHR, 32'h4B);
    stall_f = 0;
    cyc();
    stall_f = 1;
    expect_val("shift_ghr", GHR, 32'h96);
    cyc();
    expect_val("shift_once_ghr", GHR, 32'h96);
    pc_f = 32'hFFFF_FFFF;
    expect_val("wrap_ppc", PPC, 32'h3);
    train(32'hFFFF_FFFC, 32'h0, 8'h00, 1, 0);
    expect_val("wrap_mpc", MPC, 32'h0);
    cyc();
    update_e = 0;
    reset = 1;
    cyc();
    reset = 0; pc_f = 32'h40;
    expect_val("mid_bf", BF, 0); expect_val("mid_ppc", PPC, 32'h44); expect_val("mid_ghr", GHR, 0);
    expect_val("mid_sb", SB, 0); expect_val("mid_sm", SM, 0);
    cyc();
    pc_f = 32'h100;
    expect_val("mid_btb_bf", BF, 0); expect_val("mid_btb_ppc", PPC, 32'h104);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
